// File: rtl/lpddr_reg_pkg.sv
// Shared definitions for the LPDDR controller APB configuration register bank.
// Holds default geometry, the register access modes and the byte-strobe mask helper.
package lpddr_reg_pkg;

   localparam int unsigned DEF_ADDR_WIDTH = 12;
   localparam int unsigned DEF_DATA_WIDTH = 32;
   localparam int unsigned DEF_NUM_REGS   = 16;

   // Widest data bus the strobe helper supports; callers size-cast the result down.
   localparam int unsigned MAX_DATA_WIDTH = 128;
   localparam int unsigned MAX_STRB_WIDTH = MAX_DATA_WIDTH / 8;

   typedef enum logic [1:0] {
      RW,
      RO,
      W1C
   } reg_mode_e;

   function automatic logic [MAX_DATA_WIDTH-1:0] strb_to_mask(
      input logic [MAX_STRB_WIDTH-1:0] strb
   );
      logic [MAX_DATA_WIDTH-1:0] mask;
      mask = '0;
      for (int b = 0; b < MAX_STRB_WIDTH; b++) begin
         mask[b*8 +: 8] = {8{strb[b]}};
      end
      return mask;
   endfunction

endpackage

// File: rtl/apb_wait_ctrl.sv
// APB access-phase wait-state counter and pready generation.
// The access phase lasts exactly WAIT_STATES+1 cycles; the counter clears on completion.
module apb_wait_ctrl #(
   parameter int unsigned WAIT_STATES = 0
) (
   input  logic pclk,
   input  logic presetn,
   input  logic psel,
   input  logic penable,
   output logic pready
);

   localparam logic [3:0] WaitCnt = 4'(WAIT_STATES);

   logic [3:0] cnt_q, cnt_d;

   assign pready = psel & penable & (cnt_q == WaitCnt);

   always_comb begin
      cnt_d = cnt_q;
      if (!psel || pready) begin
         cnt_d = '0;
      end else if (penable) begin
         cnt_d = cnt_q + 4'd1;
      end
   end

   always_ff @(posedge pclk) begin
      if (!presetn) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/lpddr_apb_regfile.sv
// Parametrised APB4 configuration register bank with byte strobes, wait states,
// decode/access errors on pslverr, and per-register RW / RO / W1C behaviour.
module lpddr_apb_regfile
   import lpddr_reg_pkg::*;
#(
   parameter int unsigned                    ADDR_WIDTH  = DEF_ADDR_WIDTH,
   parameter int unsigned                    DATA_WIDTH  = DEF_DATA_WIDTH,
   parameter int unsigned                    NUM_REGS    = DEF_NUM_REGS,
   parameter int unsigned                    WAIT_STATES = 0,
   parameter logic [NUM_REGS-1:0]            RO_MASK     = '0,
   parameter logic [NUM_REGS-1:0]            W1C_MASK    = '0,
   parameter logic [NUM_REGS*DATA_WIDTH-1:0] RESET_VAL   = '0
) (
   input  logic                           pclk,
   input  logic                           presetn,
   input  logic [ADDR_WIDTH-1:0]          paddr,
   input  logic [DATA_WIDTH-1:0]          pwdata,
   input  logic [DATA_WIDTH/8-1:0]        pstrb,
   input  logic                           pwrite,
   input  logic                           psel,
   input  logic                           penable,
   output logic                           pready,
   output logic [DATA_WIDTH-1:0]          prdata,
   output logic                           pslverr,
   input  logic [NUM_REGS*DATA_WIDTH-1:0] hw_rdata,
   input  logic [NUM_REGS*DATA_WIDTH-1:0] hw_set,
   output logic [NUM_REGS*DATA_WIDTH-1:0] reg_q,
   output logic [NUM_REGS-1:0]            wr_pulse
);

   localparam int unsigned IdxW = ADDR_WIDTH - 2;

   logic [IdxW-1:0]                     idx;
   logic [NUM_REGS-1:0]                 sel;
   logic                                err;
   logic                                wr_ok;
   logic                                rd_ok;
   logic [DATA_WIDTH-1:0]               wmask;
   logic [MAX_STRB_WIDTH-1:0]           strb_ext;
   logic [NUM_REGS:0][DATA_WIDTH-1:0]   rd_acc;
   logic [NUM_REGS-1:0]                 wr_pulse_d;

   apb_wait_ctrl #(
      .WAIT_STATES(WAIT_STATES)
   ) u_wait (
      .pclk   (pclk),
      .presetn(presetn),
      .psel   (psel),
      .penable(penable),
      .pready (pready)
   );

   assign idx      = paddr[ADDR_WIDTH-1:2];
   assign strb_ext = MAX_STRB_WIDTH'(pstrb);
   assign wmask    = DATA_WIDTH'(strb_to_mask(strb_ext));

   // An index past NUM_REGS selects nothing, which doubles as the range check.
   assign err     = (paddr[1:0] != 2'b00) | ~(|sel) | (pwrite & |(sel & RO_MASK));
   assign pslverr = pready & err;
   assign wr_ok   = pready & pwrite & ~err;
   assign rd_ok   = pready & ~pwrite & ~err;

   assign rd_acc[0] = '0;
   assign prdata    = rd_ok ? rd_acc[NUM_REGS] : '0;

   for (genvar g = 0; g < NUM_REGS; g++) begin : g_reg
      localparam reg_mode_e Mode = RO_MASK[g] ? RO : (W1C_MASK[g] ? W1C : RW);
      localparam logic [DATA_WIDTH-1:0] RstVal =
         (Mode == RO) ? '0 : RESET_VAL[g*DATA_WIDTH +: DATA_WIDTH];

      logic [DATA_WIDTH-1:0] val_q, val_d, rd_val;

      assign sel[g] = (idx == IdxW'(g));

      always_comb begin
         val_d = val_q;
         if (Mode == RW) begin
            if (wr_ok && sel[g]) begin
               val_d = (val_q & ~wmask) | (pwdata & wmask);
            end
         end else if (Mode == W1C) begin
            if (wr_ok && sel[g]) begin
               val_d = val_q & ~(pwdata & wmask);
            end
            // Applied after the clear so a simultaneous hardware set wins.
            val_d = val_d | hw_set[g*DATA_WIDTH +: DATA_WIDTH];
         end else begin
            val_d = '0;
         end
      end

      always_ff @(posedge pclk) begin
         if (!presetn) begin
            val_q <= RstVal;
         end else begin
            val_q <= val_d;
         end
      end

      assign rd_val      = (Mode == RO) ? hw_rdata[g*DATA_WIDTH +: DATA_WIDTH] : val_q;
      assign rd_acc[g+1] = rd_acc[g] | (sel[g] ? rd_val : '0);
      assign reg_q[g*DATA_WIDTH +: DATA_WIDTH] = val_q;
   end

   assign wr_pulse_d = wr_ok ? sel : '0;

   always_ff @(posedge pclk) begin
      if (!presetn) begin
         wr_pulse <= '0;
      end else begin
         wr_pulse <= wr_pulse_d;
      end
   end

endmodule

// File: tb/tb_lpddr_apb_regfile.sv
// Directed self-checking bench for lpddr_apb_regfile: a zero-wait instance and a
// three-wait instance share the APB bus and are selected by their own psel.
module tb_lpddr_apb_regfile;

   localparam int unsigned NR = 16;
   localparam int unsigned DW = 32;

   function automatic logic [31:0] rv(input int i);
      if (i == 1 || i == 3) return 32'h0;
      return 32'hA500_0000 | (32'(i) * 32'h0000_0101);
   endfunction

   function automatic logic [NR*DW-1:0] mk_rst();
      logic [NR*DW-1:0] v;
      for (int i = 0; i < NR; i++) v[i*DW +: DW] = rv(i);
      return v;
   endfunction

   localparam logic [NR*DW-1:0] RstVal  = mk_rst();
   localparam logic [NR-1:0]    RoMask  = 16'h0020;
   localparam logic [NR-1:0]    W1cMask = 16'h0008;

   logic              pclk = 1'b0;
   logic              presetn;
   logic [11:0]       paddr;
   logic [DW-1:0]     pwdata;
   logic [3:0]        pstrb;
   logic              pwrite, penable, psel0, psel1;
   logic [NR*DW-1:0]  hw_rdata, hw_set;
   logic              pready0, pslverr0, pready1, pslverr1;
   logic [DW-1:0]     prdata0, prdata1;
   logic [NR*DW-1:0]  reg_q0, reg_q1;
   logic [NR-1:0]     wr_pulse0, wr_pulse1;

   int total = 0;
   int bad   = 0;

   always #5 pclk = ~pclk;

   lpddr_apb_regfile #(
      .WAIT_STATES(0), .RO_MASK(RoMask), .W1C_MASK(W1cMask), .RESET_VAL(RstVal)
   ) u_dut0 (
      .pclk(pclk), .presetn(presetn), .paddr(paddr), .pwdata(pwdata), .pstrb(pstrb),
      .pwrite(pwrite), .psel(psel0), .penable(penable), .pready(pready0),
      .prdata(prdata0), .pslverr(pslverr0), .hw_rdata(hw_rdata), .hw_set(hw_set),
      .reg_q(reg_q0), .wr_pulse(wr_pulse0)
   );

   lpddr_apb_regfile #(
      .WAIT_STATES(3), .RO_MASK(RoMask), .W1C_MASK(W1cMask), .RESET_VAL(RstVal)
   ) u_dut1 (
      .pclk(pclk), .presetn(presetn), .paddr(paddr), .pwdata(pwdata), .pstrb(pstrb),
      .pwrite(pwrite), .psel(psel1), .penable(penable), .pready(pready1),
      .prdata(prdata1), .pslverr(pslverr1), .hw_rdata(hw_rdata), .hw_set(hw_set),
      .reg_q(reg_q1), .wr_pulse(wr_pulse1)
   );

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%h expected=%h", tag, got, exp);
      end
   endtask

   // One full APB transfer; returns captured prdata/pslverr and access cycles before pready.
   task automatic apb(input bit inst, input bit wr, input logic [11:0] addr,
                      input logic [31:0] data, input logic [3:0] strb,
                      output logic [31:0] rd, output logic er, output int waits);
      bit done;
      done  = 1'b0;
      rd    = '0;
      er    = 1'b0;
      waits = 0;
      @(posedge pclk); #1;
      psel0 = !inst; psel1 = inst; penable = 1'b0;
      pwrite = wr; paddr = addr; pwdata = data; pstrb = strb;
      @(posedge pclk); #1;
      penable = 1'b1;
      for (int n = 0; n < 40 && !done; n++) begin
         @(negedge pclk);
         if (inst ? pready1 : pready0) begin
            done  = 1'b1;
            waits = n;
            rd    = inst ? prdata1 : prdata0;
            er    = inst ? pslverr1 : pslverr0;
         end else begin
            @(posedge pclk); #1;
         end
      end
      if (!done) check_eq("pready_timeout", 32'd0, 32'd1);
      @(posedge pclk); #1;
      psel0 = 1'b0; psel1 = 1'b0; penable = 1'b0; pwrite = 1'b0;
   endtask

   task automatic rd_chk(input bit inst, input int r, input logic [31:0] exp, input string tag);
      logic [31:0] rd;
      logic        er;
      int          w;
      apb(inst, 1'b0, 12'(4 * r), 32'h0, 4'h0, rd, er, w);
      check_eq({tag, "_data"}, rd, exp);
      check_eq({tag, "_err"}, 32'(er), 32'd0);
      check_eq({tag, "_waits"}, 32'(w), inst ? 32'd3 : 32'd0);
   endtask

   logic [31:0] exp_q [NR];
   logic [31:0] rd;
   logic        er;
   int          w;

   initial begin
      presetn = 1'b0; paddr = '0; pwdata = '0; pstrb = '0;
      pwrite = 1'b0; penable = 1'b0; psel0 = 1'b0; psel1 = 1'b0;
      hw_set = '0;
      for (int i = 0; i < NR; i++) hw_rdata[i*DW +: DW] = 32'hC0DE_0000 | 32'(i);
      for (int i = 0; i < NR; i++) exp_q[i] = (i == 5) ? 32'h0 : rv(i);

      repeat (2) @(posedge pclk);
      @(negedge pclk);
      check_eq("rst_pready", 32'(pready0), 32'd0);
      check_eq("rst_prdata", prdata0, 32'h0);
      check_eq("rst_pslverr", 32'(pslverr0), 32'd0);
      check_eq("rst_wr_pulse", 32'(wr_pulse0), 32'h0);
      check_eq("rst_reg0", reg_q0[0 +: 32], 32'hA500_0000);
      @(posedge pclk); #1;
      presetn = 1'b1;

      // Every index reads its reset value; RO reg 5 reads the hardware value.
      for (int i = 0; i < NR; i++) begin
         rd_chk(1'b0, i, (i == 5) ? 32'hC0DE_0005 : rv(i), $sformatf("rst_rd%0d", i));
      end
      check_eq("ro_reg_q_zero", reg_q0[5*DW +: DW], 32'h0);

      // Wait-state instance: write then read back reg 2.
      apb(1'b1, 1'b1, 12'h008, 32'hDEAD_BEEF, 4'hF, rd, er, w);
      check_eq("ws_wr_err", 32'(er), 32'd0);
      check_eq("ws_wr_waits", 32'(w), 32'd3);
      @(negedge pclk);
      check_eq("ws_wr_pulse_hi", 32'(wr_pulse1), 32'h0004);
      @(negedge pclk);
      check_eq("ws_wr_pulse_lo", 32'(wr_pulse1), 32'h0000);
      rd_chk(1'b1, 2, 32'hDEAD_BEEF, "ws_rd2");

      // Partial strobe on reg 1.
      apb(1'b0, 1'b1, 12'h004, 32'hFFFF_FFFF, 4'b0101, rd, er, w);
      exp_q[1] = 32'h00FF_00FF;
      rd_chk(1'b0, 1, 32'h00FF_00FF, "strb_rd1");

      // Error accesses: misaligned, out of range, write to RO.
      apb(1'b0, 1'b1, 12'h041, 32'h1234_5678, 4'hF, rd, er, w);
      check_eq("err_misalign", 32'(er), 32'd1);
      @(negedge pclk);
      check_eq("err_misalign_pulse", 32'(wr_pulse0), 32'h0);
      apb(1'b0, 1'b1, 12'h040, 32'h1234_5678, 4'hF, rd, er, w);
      check_eq("err_range", 32'(er), 32'd1);
      @(negedge pclk);
      check_eq("err_range_pulse", 32'(wr_pulse0), 32'h0);
      apb(1'b0, 1'b1, 12'h014, 32'h1234_5678, 4'hF, rd, er, w);
      check_eq("err_ro", 32'(er), 32'd1);
      @(negedge pclk);
      check_eq("err_ro_pulse", 32'(wr_pulse0), 32'h0);
      apb(1'b0, 1'b0, 12'h006, 32'h0, 4'h0, rd, er, w);
      check_eq("err_rd_misalign", 32'(er), 32'd1);
      check_eq("err_rd_data", rd, 32'h0);

      // Zero-strobe write is a no-op that still pulses.
      apb(1'b0, 1'b1, 12'h010, 32'h5555_5555, 4'h0, rd, er, w);
      check_eq("nostrb_err", 32'(er), 32'd0);
      @(negedge pclk);
      check_eq("nostrb_pulse", 32'(wr_pulse0), 32'h0010);
      for (int i = 0; i < NR; i++) begin
         check_eq($sformatf("regq%0d", i), reg_q0[i*DW +: DW], exp_q[i]);
      end

      // W1C reg 3: hardware set, set-vs-clear collision, then plain clear.
      @(posedge pclk); #1;
      hw_set[3*DW +: DW] = 32'h5;
      hw_set[4*DW +: DW] = 32'hFFFF_FFFF;
      @(posedge pclk); #1;
      hw_set = '0;
      rd_chk(1'b0, 3, 32'h5, "w1c_set");
      rd_chk(1'b0, 4, rv(4), "rw_ignores_set");
      rd_chk(1'b0, 3, 32'h5, "w1c_rd_no_clear");
      hw_set[3*DW +: DW] = 32'h1;
      apb(1'b0, 1'b1, 12'h00C, 32'h1, 4'hF, rd, er, w);
      hw_set = '0;
      rd_chk(1'b0, 3, 32'h5, "w1c_set_wins");
      apb(1'b0, 1'b1, 12'h00C, 32'h1, 4'hF, rd, er, w);
      rd_chk(1'b0, 3, 32'h4, "w1c_clear");

      // Reset during the wait phase of a write to reg 0 on the wait-state instance.
      @(posedge pclk); #1;
      psel1 = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 12'h000;
      pwdata = 32'h1111_1111; pstrb = 4'hF;
      @(posedge pclk); #1;
      penable = 1'b1;
      @(negedge pclk);
      check_eq("abort_wait0", 32'(pready1), 32'd0);
      @(posedge pclk); #1;
      presetn = 1'b0;
      @(posedge pclk); #1;
      @(negedge pclk);
      check_eq("abort_pready", 32'(pready1), 32'd0);
      check_eq("abort_reg0", reg_q1[0 +: 32], 32'hA500_0000);
      check_eq("abort_pulse", 32'(wr_pulse1), 32'h0);
      @(posedge pclk); #1;
      presetn = 1'b1; psel1 = 1'b0; penable = 1'b0; pwrite = 1'b0;
      rd_chk(1'b1, 0, 32'hA500_0000, "abort_rd0");
      rd_chk(1'b1, 2, 32'hA500_0202, "abort_rd2");
      apb(1'b1, 1'b1, 12'h000, 32'h2222_2222, 4'hF, rd, er, w);
      check_eq("post_wr_err", 32'(er), 32'd0);
      check_eq("post_wr_waits", 32'(w), 32'd3);
      rd_chk(1'b1, 0, 32'h2222_2222, "post_rd0");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got=timeout expected=finish");
      $fatal(1);
   end

endmodule

// File: doc/lpddr_apb_regfile.md
Name: lpddr_apb_regfile

Overview:
Parametrised APB4 configuration register bank for the LPDDR controller. It generalises the existing fixed zero-wait APB register array in four ways:
- configurable depth, width and wait states;
- byte strobes;
- decode and access errors reported on pslverr;
- per-register read-only (RO) and write-1-to-clear (W1C) modes.
It sits beside the AXI RAM datapath and drives controller configuration and status.

Parameters:
ADDR_WIDTH, 12, APB byte-address width.
DATA_WIDTH, 32, register and APB data width; must be a multiple of 8.
NUM_REGS, 16, number of registers; register i sits at byte address 4*i.
WAIT_STATES, 0, extra access-phase cycles before pready (0..15).
RO_MASK, NUM_REGS'b0, bit i set means register i is read-only and reads hw_rdata slice i.
W1C_MASK, NUM_REGS'b0, bit i set means register i is W1C with hardware set.
RESET_VAL, '0, flattened NUM_REGS*DATA_WIDTH reset values for RW and W1C registers.

Ports:
pclk  in  1  clock
presetn  in  1  synchronous active-low reset
paddr  in  ADDR_WIDTH  byte address
pwdata  in  DATA_WIDTH  write data
pstrb  in  DATA_WIDTH/8  write byte strobes
pwrite  in  1  1 = write
psel  in  1  select
penable  in  1  access phase
pready  out  1  transfer complete
prdata  out  DATA_WIDTH  read data, valid when pready
pslverr  out  1  error, valid when pready
hw_rdata  in  NUM_REGS*DATA_WIDTH  values read back by RO registers
hw_set  in  NUM_REGS*DATA_WIDTH  per-bit set pulses for W1C registers
reg_q  out  NUM_REGS*DATA_WIDTH  current register contents (RO slices read 0)
wr_pulse  out  NUM_REGS  one-cycle strobe the cycle after a successful write

Behaviour:
Clocking and reset:
- One clock. Reset is synchronous and active-low: presetn sampled low at a pclk edge resets state.
- On reset:
  - registers take RESET_VAL;
  - wait counter = 0, wr_pulse = 0;
  - pready/pslverr/prdata follow their combinational definitions with counter 0.
- Reset asserted mid-transfer aborts the transfer with no register update. The master must restart from the setup phase.

Handshake:
- The setup phase (psel & !penable) has no effect.
- Access phase (psel & penable): a 4-bit counter cnt increments each access cycle while pready = 0.
- pready = psel & penable & (cnt == WAIT_STATES). The access phase therefore lasts exactly WAIT_STATES+1 cycles.
- WAIT_STATES = 0 gives zero-wait behaviour: pready high in the first access cycle.
- cnt clears on the completing edge, or whenever psel = 0.
- pready = 0 whenever psel = 0.

Decode:
- idx = paddr[ADDR_WIDTH-1:2].
- err = (paddr[1:0] != 0) | (idx >= NUM_REGS) | (pwrite & RO_MASK[idx]).
- pslverr = pready & err.

Write (on the completing edge, when err = 0):
- RW register: update byte b where pstrb[b] = 1.
- W1C register: clear bits where pwdata & strobe-expanded mask = 1.
- pstrb = 0 is a legal no-op write; wr_pulse still fires.
- A write with err = 1 changes nothing and produces no wr_pulse.

W1C hardware set:
- Every cycle, reg |= hw_set slice, for W1C registers only.
- Set and software clear of the same bit in the same cycle: set wins, bit = 1.
- hw_set is ignored for RW and RO registers.

Read:
- prdata = pready & !pwrite & !err ? (RO ? hw_rdata slice : reg) : 0.
- Reads never alter state, including W1C registers.

wr_pulse:
- wr_pulse[idx] is registered and high for exactly one cycle after the completing edge of a successful write.

Decomposition:
Package lpddr_reg_pkg holds:
- DATA_WIDTH, ADDR_WIDTH and NUM_REGS defaults;
- the reg_mode_e enum {RW, RO, W1C};
- the byte-strobe expansion function.

Sub-module apb_wait_ctrl holds the cnt counter and pready generation, so the AXI-side register blocks can reuse it.

Test Plan:
- Reset, then read every index with WAIT_STATES=0 -> pready in the first access cycle; prdata = RESET_VAL slice; pslverr = 0.
- WAIT_STATES=3: write 0xDEADBEEF to reg 2, then read it back -> pready in access cycle 4; read returns 0xDEADBEEF; wr_pulse[2] high for one cycle after the write.
- Write 0xFFFFFFFF to reg 1 with pstrb=4'b0101 (reg reset 0) -> read returns 0x00FF00FF.
- Write to paddr 0x041 (misaligned), paddr 0x040 (idx 16 >= NUM_REGS), and an RO register -> pslverr = 1 with pready; no register changes; no wr_pulse.
- W1C reg 3: hw_set=0x5 for one cycle -> reads 0x5. Then write 0x1 in the same cycle hw_set=0x1 -> stays 0x5. Write 0x1 alone -> reads 0x4.
- Deassert presetn during the wait phase of a write to reg 0 -> reg 0 = RESET_VAL, pready = 0, and the next transfer completes normally.
